// File: rtl/vball_pkg.sv
// rtl/vball_pkg.sv - shared sprite-RAM geometry, entry layout and DMA state encoding
package vball_pkg;

    localparam int SPR_RAM_AW = 8;
    localparam int SPR_RAM_DW = 8;

    // Byte offsets inside one 4-byte sprite entry
    localparam int SPR_Y    = 0;
    localparam int SPR_ATTR = 1;
    localparam int SPR_ID   = 2;
    localparam int SPR_X    = 3;

    typedef logic [1:0] dma_state_t;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_COPY  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/vball_sprite_dma_if.sv
// rtl/vball_sprite_dma_if.sv - CPU, trigger and renderer signals of the sprite DMA
interface vball_sprite_dma_if;
    import vball_pkg::*;

    logic                  cpu_cs;
    logic                  cpu_we;
    logic [SPR_RAM_AW-1:0] cpu_addr;
    logic [SPR_RAM_DW-1:0] cpu_din;
    logic [SPR_RAM_DW-1:0] cpu_dout;
    logic                  dma_trig;
    logic [8:0]            vcount;
    logic [SPR_RAM_AW-1:0] sma;
    logic [SPR_RAM_DW-1:0] smd;
    logic                  dma_busy;
    logic                  dma_ovr;

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_din, dma_trig, vcount, sma,
        input  cpu_dout, smd, dma_busy, dma_ovr
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_din, dma_trig, vcount, sma,
        output cpu_dout, smd, dma_busy, dma_ovr
    );

endinterface

// File: rtl/vball_dpram_256x8.sv
// rtl/vball_dpram_256x8.sv - 256x8 dual-port RAM, port A read/write, port B read-only
module vball_dpram_256x8
    import vball_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  we_a_i,
    input  logic [SPR_RAM_AW-1:0] addr_a_i,
    input  logic [SPR_RAM_DW-1:0] din_a_i,
    output logic [SPR_RAM_DW-1:0] dout_a_o,
    input  logic [SPR_RAM_AW-1:0] addr_b_i,
    output logic [SPR_RAM_DW-1:0] dout_b_o
);

    logic [SPR_RAM_DW-1:0] mem_q [0:(1<<SPR_RAM_AW)-1];

    // Storage write; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= din_a_i;
        end
    end

    // Registered reads sample the array before this edge's write lands (old data)
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            dout_a_o <= '0;
            dout_b_o <= '0;
        end else begin
            dout_a_o <= mem_q[addr_a_i];
            dout_b_o <= mem_q[addr_b_i];
        end
    end

endmodule

// File: rtl/vball_sprite_dma.sv
// rtl/vball_sprite_dma.sv - work/display sprite buffers with per-frame copy and post-reset clear
module vball_sprite_dma
    import vball_pkg::*;
#(
    parameter logic [8:0] VBL_LINE = 9'd240,
    parameter bit         AUTO_DMA = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    vball_sprite_dma_if.slave bus
);

    dma_state_t            state_q, state_d;
    logic [SPR_RAM_AW-1:0] cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic [8:0]            vcl_q;

    logic                  auto_trig;
    logic                  trig;
    logic                  disp_we;
    logic [SPR_RAM_AW-1:0] disp_addr;
    logic [SPR_RAM_DW-1:0] disp_din;
    logic [SPR_RAM_DW-1:0] work_rd;
    logic [SPR_RAM_DW-1:0] disp_old_unused;

    // Only the edge into VBL_LINE fires, so a stalled vcount cannot retrigger
    assign auto_trig = AUTO_DMA && (vcl_q != bus.vcount) && (bus.vcount == VBL_LINE);
    assign trig      = auto_trig || bus.dma_trig;

    // Work buffer: CPU on port A, DMA reads on port B at the running counter
    vball_dpram_256x8 u_work (
        .clk_i    (clk_sys),
        .resetn_i (reset_n),
        .we_a_i   (bus.cpu_cs && bus.cpu_we),
        .addr_a_i (bus.cpu_addr),
        .din_a_i  (bus.cpu_din),
        .dout_a_o (bus.cpu_dout),
        .addr_b_i (cnt_q),
        .dout_b_o (work_rd)
    );

    // Display buffer: DMA/clear writes on port A, renderer reads on port B
    vball_dpram_256x8 u_disp (
        .clk_i    (clk_sys),
        .resetn_i (reset_n),
        .we_a_i   (disp_we),
        .addr_a_i (disp_addr),
        .din_a_i  (disp_din),
        .dout_a_o (disp_old_unused),
        .addr_b_i (bus.sma),
        .dout_b_o (bus.smd)
    );

    // Next-state: clear/copy sequencing plus one-deep trigger queue with overflow flag
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        ovr_d     = ovr_q;
        disp_we   = 1'b0;
        disp_addr = cnt_q;
        disp_din  = '0;
        case (state_q)
            ST_CLEAR: begin
                disp_we = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                busy_d = 1'b0;
                if (trig || pending_q) begin
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_COPY;
                end
            end
            ST_COPY: begin
                // Read data lags the address by one cycle, so write one slot behind
                disp_we   = (cnt_q != 8'h00);
                disp_addr = cnt_q - 8'd1;
                disp_din  = work_rd;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                disp_we   = 1'b1;
                disp_addr = 8'hFF;
                disp_din  = work_rd;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if ((state_q != ST_IDLE) && trig) begin
            if (pending_q) begin
                ovr_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // State registers; reset aborts any pass and restarts the display clear
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            ovr_q     <= 1'b0;
            vcl_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            vcl_q     <= bus.vcount;
        end
    end

    assign bus.dma_busy = busy_q;
    assign bus.dma_ovr  = ovr_q;

endmodule
